// File: rtl/dlfloat_mac_sequencer.sv
// dlfloat_mac_sequencer: streams a dot-product job into the DLFloat16 MAC and returns the accumulated result.
module dlfloat_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_cfg_len,
  output logic             o_busy,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [15:0]      i_in_a,
  input  logic [15:0]      i_in_b,
  output logic [15:0]      o_mac_a,
  output logic [15:0]      o_mac_b,
  output logic             o_mac_clr,
  input  logic [15:0]      i_acc_in,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [15:0]      o_res_data,
  output logic             o_res_sat
);
  localparam int DW = $clog2(LAT + 2);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t           r_state;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [DW-1:0]    r_dcnt;
  logic             r_sat;
  logic             w_acc;
  assign o_busy      = r_state != IDLE;
  assign o_in_ready  = r_state == FEED;
  assign o_mac_clr   = r_state == CLEAR;
  assign o_res_valid = r_state == DONE;
  assign o_res_sat   = r_sat;
  assign w_acc       = i_in_valid & o_in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      r_sat      <= 1'b0;
      o_mac_a    <= '0;
      o_mac_b    <= '0;
      o_res_data <= '0;
    end else begin
      // operands fall back to zero so idle cycles add nothing to the accumulator
      o_mac_a <= w_acc ? i_in_a : '0;
      o_mac_b <= w_acc ? i_in_b : '0;
      case (r_state)
        IDLE: if (i_start) begin
          r_len   <= i_cfg_len;
          r_cnt   <= '0;
          r_state <= CLEAR;
        end
        CLEAR: begin
          r_sat   <= 1'b0;
          r_dcnt  <= '0;
          r_state <= r_len != '0 ? FEED : DRAIN;
        end
        FEED: if (w_acc) begin
          r_cnt <= r_cnt + 1'b1;
          r_sat <= r_sat | (i_in_a == 16'hFFFF) | (i_in_b == 16'hFFFF);
          if (r_cnt == r_len - 1'b1) r_state <= DRAIN;
        end
        DRAIN: if (r_dcnt == DW'(LAT)) begin
          o_res_data <= i_acc_in;
          r_sat      <= r_sat | (i_acc_in == 16'hFFFF);
          r_state    <= DONE;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
        DONE: if (i_res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// tb_dlfloat_mac_sequencer: directed jobs against a behavioural two-stage DLFloat16 MAC.
module tb_dlfloat_mac_sequencer;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [7:0]  cfg_len = 0;
  logic [15:0] in_a = 0, in_b = 0, acc_in;
  logic        busy, in_ready, mac_clr, res_valid, res_sat;
  logic [15:0] mac_a, mac_b, res_data;
  int          cyc = 0, errs = 0, checks = 0, s;
  real         r_p = 0.0, r_acc = 0.0;
  logic        psat = 0, asat = 0;

  dlfloat_mac_sequencer #(.LEN_W(8), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_cfg_len(cfg_len), .o_busy(busy),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
    .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_clr(mac_clr), .i_acc_in(acc_in),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data), .o_res_sat(res_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real d2r(logic [15:0] x);
    real m;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]);
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i < 31; i++) m = m / 2.0;
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2d(real r);
    real  m;
    int   e;
    logic sg;
    if (r == 0.0) return 16'h0000;
    sg = r < 0.0;
    m  = sg ? -r : r;
    e  = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {sg, 6'(e), 9'($rtoi((m - 1.0) * 512.0))};
  endfunction

  // multiplier register then accumulator register; an all-ones operand saturates sticky
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p <= 0.0; psat <= 0; r_acc <= 0.0; asat <= 0;
    end else begin
      r_p  <= d2r(mac_a) * d2r(mac_b);
      psat <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
      r_acc <= mac_clr ? 0.0 : r_acc + r_p;
      asat  <= mac_clr ? 1'b0 : asat | psat;
    end
  assign acc_in = asat ? 16'hFFFF : r2d(r_acc);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int n, output int st);
    cfg_len = 8'(n);
    start   = 1;
    step();
    start = 0;
    st    = cyc;
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b);
    bit done = 0;
    in_a = a; in_b = b; in_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      step();
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic result(string tag, int st, int lat, logic [15:0] d, logic sat);
    int i = 0;
    while (!res_valid && i < 50) begin step(); i++; end
    chk({tag, "_lat"}, cyc - st, lat);
    chk({tag, "_data"}, res_data, d);
    chk({tag, "_sat"}, res_sat, sat);
    res_ready = 1;
    step();
    res_ready = 0;
    chk({tag, "_done"}, {busy, res_valid}, 0);
  endtask

  initial begin
    #2;
    chk("rst_outs", {busy, in_ready, mac_clr, res_valid, res_sat}, 0);
    chk("rst_data", {mac_a, mac_b}, 0);
    chk("rst_res", res_data, 0);
    #11 rst_n = 1;
    step();
    // four ones back-to-back
    go(4, s);
    chk("t1_clear", {busy, mac_clr, in_ready}, 3'b110);
    chk("t1_mac0", {mac_a, mac_b}, 0);
    send(16'h3E00, 16'h3E00);
    chk("t1_mac_a", mac_a, 16'h3E00);
    chk("t1_clr_off", mac_clr, 0);
    repeat (3) send(16'h3E00, 16'h3E00);
    result("t1", s, 8, 16'h4200, 0);
    // sign cancellation across bubbles
    go(2, s);
    send(16'h4000, 16'h3E00);
    step();
    chk("t2_bub1", {in_ready, mac_a}, {1'b1, 16'h0000});
    step();
    chk("t2_bub2", in_ready, 1);
    send(16'hBE00, 16'h3E00);
    result("t2", s, 8, 16'h3E00, 0);
    // zero length with backpressure and an ignored start
    go(0, s);
    repeat (3) step();
    chk("t3_early", res_valid, 0);
    step();
    chk("t3_lat", {res_valid, 16'(cyc - s)}, {1'b1, 16'd4});
    chk("t3_data", res_data, 0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("t3_hold", {res_valid, res_data}, {1'b1, 16'h0000});
    end
    start = 0; res_ready = 1;
    step();
    res_ready = 0;
    chk("t3_release", {busy, res_valid}, 0);
    step();
    chk("t3_noqueue", busy, 0);
    // saturation then a clean job
    go(3, s);
    send(16'h3E00, 16'h3E00);
    send(16'hFFFF, 16'h3E00);
    send(16'h3E00, 16'h3E00);
    result("t4sat", s, 7, 16'hFFFF, 1);
    go(1, s);
    send(16'h3E00, 16'h3E00);
    result("t4clr", s, 5, 16'h3E00, 0);
    // reset mid-feed
    go(4, s);
    send(16'h3E00, 16'h3E00);
    send(16'h3E00, 16'h3E00);
    rst_n = 0;
    #1;
    chk("t5_outs", {busy, in_ready, mac_clr, res_valid, res_sat}, 0);
    chk("t5_mac", {mac_a, mac_b}, 0);
    chk("t5_res", res_data, 0);
    #2 rst_n = 1;
    step();
    chk("t5_idle", busy, 0);
    go(1, s);
    send(16'h4000, 16'h3E00);
    result("t5", s, 5, 16'h4000, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
